// File: rtl/exp_3x3_pkg.sv
// Shared types and constants for the expand 3x3 kernel RAM write controller.
// Optional feature macro: EXP3_KER_WR_ERR_CHK_EN (see exp_3x3_ker_write_cont).
package exp_3x3_pkg;

  localparam int RAM_AW = 7;

  localparam logic [RAM_AW-1:0] LAYER1_BASE = 7'd0;
  localparam logic [RAM_AW-1:0] LAYER2_BASE = 7'd64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FREE = 2'd1,
    WRITE     = 2'd2,
    END       = 2'd3
  } state_e;

endpackage

// File: rtl/exp_3x3_layer_flag.sv
// One ping-pong layer ready flag: set when the layer's last RAM write has
// landed, cleared by the reader's done pulse or by a restart.
// Optional feature macro: EXP3_KER_WR_ERR_CHK_EN adds err_pulse_o.
module exp_3x3_layer_flag
  import exp_3x3_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic start_i,
  input  logic set_i,
  input  logic done_i,
  output logic ready_o
`ifdef EXP3_KER_WR_ERR_CHK_EN
  ,
  output logic err_pulse_o
`endif
);

  logic ready_d, ready_q;

  // Next flag value: restart wins, then set, then the reader's release.
  // Set and done never coincide because a layer is only written while free.
  always_comb begin
    ready_d = ready_q;
    if (start_i) begin
      ready_d = 1'b0;
    end else if (set_i) begin
      ready_d = 1'b1;
    end else if (done_i) begin
      ready_d = 1'b0;
    end
  end

  // Flag register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= ready_d;
    end
  end

  assign ready_o = ready_q;

`ifdef EXP3_KER_WR_ERR_CHK_EN
  // A done pulse for a layer that holds nothing is a protocol error.
  assign err_pulse_o = done_i & ~ready_q;
`endif

endmodule

// File: rtl/exp_3x3_ker_write_cont.sv
// Expand 3x3 kernel RAM write controller. Streams loader words into the
// ping-pong kernel RAM (layer 1 at 0.., layer 2 at LAYER2_BASE..), raising a
// per-layer ready flag once the layer is complete and waiting for the reader
// to free a layer before refilling it.
// Optional feature macro: EXP3_KER_WR_ERR_CHK_EN adds the sticky err_o output.
module exp_3x3_ker_write_cont
  import exp_3x3_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter int unsigned LAYER2_BASE = 64
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic [6:0]          layer_words_i,
  input  logic [5:0]          exp3_ker_depth_i,
  input  logic [DATA_W-1:0]   ker_data_i,
  input  logic                ker_data_valid_i,
  output logic                ker_data_ready_o,
  output logic [RAM_AW-1:0]   exp_3x3_ram_wr_addr_o,
  output logic [DATA_W-1:0]   exp_3x3_ram_wr_data_o,
  output logic                exp_3x3_ram_wr_en_o,
  output logic                layer_1_ready_o,
  input  logic                layer_1_done_i,
  output logic                layer_2_ready_o,
  input  logic                layer_2_done_i,
  output logic                fill_end_o
`ifdef EXP3_KER_WR_ERR_CHK_EN
  ,
  output logic                err_o
`endif
);

  localparam logic [RAM_AW-1:0] L2_BASE = RAM_AW'(LAYER2_BASE);

  state_e              state_d, state_q;
  logic                layer_sel_d, layer_sel_q;    // 0 = layer 1, 1 = layer 2
  logic [5:0]          word_cnt_d, word_cnt_q;
  logic [5:0]          fill_cnt_d, fill_cnt_q;
  logic [6:0]          layer_words_d, layer_words_q;
  logic [5:0]          depth_d, depth_q;
  logic                wr_en_d, wr_en_q;
  logic [RAM_AW-1:0]   wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0]   wr_data_d, wr_data_q;
  logic                set1_d, set1_q;
  logic                set2_d, set2_q;

  logic                accept;
  logic                last_word;
  logic                sel_ready;
  logic [RAM_AW-1:0]   layer_base;

  assign accept     = (state_q == WRITE) && ker_data_valid_i;
  assign last_word  = ({1'b0, word_cnt_q} == layer_words_q);
  assign sel_ready  = layer_sel_q ? layer_2_ready_o : layer_1_ready_o;
  assign layer_base = layer_sel_q ? L2_BASE : LAYER1_BASE;

  // FSM, counters and write-port next state. The set pulses ride one cycle
  // behind the final write so a flag only rises after its RAM write landed.
  always_comb begin
    state_d       = state_q;
    layer_sel_d   = layer_sel_q;
    word_cnt_d    = word_cnt_q;
    fill_cnt_d    = fill_cnt_q;
    layer_words_d = layer_words_q;
    depth_d       = depth_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    set1_d        = 1'b0;
    set2_d        = 1'b0;
    if (start_i) begin
      state_d       = WAIT_FREE;
      layer_sel_d   = 1'b0;
      word_cnt_d    = '0;
      fill_cnt_d    = '0;
      layer_words_d = layer_words_i;
      depth_d       = exp3_ker_depth_i;
      wr_addr_d     = '0;
      wr_data_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT_FREE: begin
          if (!sel_ready) begin
            state_d = WRITE;
          end
        end
        WRITE: begin
          if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = layer_base + {1'b0, word_cnt_q};
            wr_data_d = ker_data_i;
            if (last_word) begin
              word_cnt_d = '0;
              set1_d     = ~layer_sel_q;
              set2_d     = layer_sel_q;
              if (fill_cnt_q == depth_q) begin
                state_d = END;
              end else begin
                fill_cnt_d  = fill_cnt_q + 6'd1;
                layer_sel_d = ~layer_sel_q;
                state_d     = WAIT_FREE;
              end
            end else begin
              word_cnt_d = word_cnt_q + 6'd1;
            end
          end
        end
        END: begin
          state_d = END;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Control and write-port registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      layer_sel_q   <= 1'b0;
      word_cnt_q    <= '0;
      fill_cnt_q    <= '0;
      layer_words_q <= '0;
      depth_q       <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      set1_q        <= 1'b0;
      set2_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      layer_sel_q   <= layer_sel_d;
      word_cnt_q    <= word_cnt_d;
      fill_cnt_q    <= fill_cnt_d;
      layer_words_q <= layer_words_d;
      depth_q       <= depth_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      set1_q        <= set1_d;
      set2_q        <= set2_d;
    end
  end

`ifdef EXP3_KER_WR_ERR_CHK_EN
  logic err1_pulse, err2_pulse;
  logic err_d, err_q;

  exp_3x3_layer_flag u_flag1 (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .set_i       (set1_q),
    .done_i      (layer_1_done_i),
    .ready_o     (layer_1_ready_o),
    .err_pulse_o (err1_pulse)
  );

  exp_3x3_layer_flag u_flag2 (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .set_i       (set2_q),
    .done_i      (layer_2_done_i),
    .ready_o     (layer_2_ready_o),
    .err_pulse_o (err2_pulse)
  );

  // Sticky error: stray done pulses or a loader pushing after the last fill.
  always_comb begin
    err_d = err_q;
    if (start_i) begin
      err_d = 1'b0;
    end else if (err1_pulse || err2_pulse ||
                 ((state_q == END) && ker_data_valid_i)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  exp_3x3_layer_flag u_flag1 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .set_i   (set1_q),
    .done_i  (layer_1_done_i),
    .ready_o (layer_1_ready_o)
  );

  exp_3x3_layer_flag u_flag2 (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .start_i (start_i),
    .set_i   (set2_q),
    .done_i  (layer_2_done_i),
    .ready_o (layer_2_ready_o)
  );
`endif

  assign ker_data_ready_o      = (state_q == WRITE);
  assign fill_end_o            = (state_q == END);
  assign exp_3x3_ram_wr_en_o   = wr_en_q;
  assign exp_3x3_ram_wr_addr_o = wr_addr_q;
  assign exp_3x3_ram_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_exp_3x3_ker_write_cont.sv
// Testbench for exp_3x3_ker_write_cont: per-cycle vector table plus directed
// restart / async reset / error-flag sequences.
module tb_exp_3x3_ker_write_cont;

  localparam int DATA_W = 64;

  logic              clk;
  logic              rst_n_i;
  logic              start_i;
  logic [6:0]        layer_words_i;
  logic [5:0]        exp3_ker_depth_i;
  logic [DATA_W-1:0] ker_data_i;
  logic              ker_data_valid_i;
  logic              ker_data_ready_o;
  logic [6:0]        exp_3x3_ram_wr_addr_o;
  logic [DATA_W-1:0] exp_3x3_ram_wr_data_o;
  logic              exp_3x3_ram_wr_en_o;
  logic              layer_1_ready_o;
  logic              layer_1_done_i;
  logic              layer_2_ready_o;
  logic              layer_2_done_i;
  logic              fill_end_o;
`ifdef EXP3_KER_WR_ERR_CHK_EN
  logic              err_o;
`endif

  exp_3x3_ker_write_cont #(.DATA_W(DATA_W), .LAYER2_BASE(64)) dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n_i),
    .start_i               (start_i),
    .layer_words_i         (layer_words_i),
    .exp3_ker_depth_i      (exp3_ker_depth_i),
    .ker_data_i            (ker_data_i),
    .ker_data_valid_i      (ker_data_valid_i),
    .ker_data_ready_o      (ker_data_ready_o),
    .exp_3x3_ram_wr_addr_o (exp_3x3_ram_wr_addr_o),
    .exp_3x3_ram_wr_data_o (exp_3x3_ram_wr_data_o),
    .exp_3x3_ram_wr_en_o   (exp_3x3_ram_wr_en_o),
    .layer_1_ready_o       (layer_1_ready_o),
    .layer_1_done_i        (layer_1_done_i),
    .layer_2_ready_o       (layer_2_ready_o),
    .layer_2_done_i        (layer_2_done_i),
    .fill_end_o            (fill_end_o)
`ifdef EXP3_KER_WR_ERR_CHK_EN
    ,
    .err_o                 (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs held for one cycle, outputs expected just after its edge.
  typedef struct {
    logic       start;
    logic       valid;
    logic [7:0] data;
    logic       d1;
    logic       d2;
    logic [6:0] lw;
    logic [5:0] dep;
    logic       rdy;
    logic       en;
    logic [6:0] addr;
    logic [7:0] edata;
    logic       l1;
    logic       l2;
    logic       fend;
  } vec_t;

  vec_t tbl[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic add(input int s, input int v, input int dat, input int d1, input int d2,
                     input int lw, input int dep, input int rdy, input int en,
                     input int addr, input int edat, input int l1, input int l2, input int fend);
    vec_t r;
    r.start = s[0];  r.valid = v[0];  r.data = dat[7:0];
    r.d1 = d1[0];    r.d2 = d2[0];    r.lw = lw[6:0];  r.dep = dep[5:0];
    r.rdy = rdy[0];  r.en = en[0];    r.addr = addr[6:0]; r.edata = edat[7:0];
    r.l1 = l1[0];    r.l2 = l2[0];    r.fend = fend[0];
    tbl.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic en,
                          input logic l1, input logic l2, input logic fend);
    chk({tag, "_rdy"},  {63'd0, ker_data_ready_o},    {63'd0, rdy});
    chk({tag, "_en"},   {63'd0, exp_3x3_ram_wr_en_o}, {63'd0, en});
    chk({tag, "_l1"},   {63'd0, layer_1_ready_o},     {63'd0, l1});
    chk({tag, "_l2"},   {63'd0, layer_2_ready_o},     {63'd0, l2});
    chk({tag, "_fend"}, {63'd0, fill_end_o},          {63'd0, fend});
  endtask

  task automatic chk_wr(input string tag, input logic [6:0] addr, input logic [7:0] dat);
    chk({tag, "_addr"}, {57'd0, exp_3x3_ram_wr_addr_o}, {57'd0, addr});
    chk({tag, "_data"}, exp_3x3_ram_wr_data_o, {56'd0, dat});
  endtask

  initial begin
    // Basic fill: 4 words, depth 0; B1 offers a word while still in WAIT_FREE
    add(1,0,8'h00,0,0,3,0, 0,0,0,8'h00,0,0,0);
    add(0,1,8'hA0,0,0,3,0, 1,0,0,8'h00,0,0,0);
    add(0,1,8'hA0,0,0,3,0, 1,1,0,8'hA0,0,0,0);
    add(0,1,8'hA1,0,0,3,0, 1,1,1,8'hA1,0,0,0);
    add(0,1,8'hA2,0,0,3,0, 1,1,2,8'hA2,0,0,0);
    add(0,1,8'hA3,0,0,3,0, 0,1,3,8'hA3,0,0,1);
    add(0,0,8'h00,0,0,3,0, 0,0,0,8'h00,1,0,1);
    add(0,1,8'h55,0,0,3,0, 0,0,0,8'h00,1,0,1);
    // Bubbles: valid toggling
    add(1,0,8'h00,0,0,3,0, 0,0,0,8'h00,0,0,0);
    add(0,0,8'h00,0,0,3,0, 1,0,0,8'h00,0,0,0);
    add(0,1,8'hB0,0,0,3,0, 1,1,0,8'hB0,0,0,0);
    add(0,0,8'h00,0,0,3,0, 1,0,0,8'h00,0,0,0);
    add(0,1,8'hB1,0,0,3,0, 1,1,1,8'hB1,0,0,0);
    add(0,0,8'h00,0,0,3,0, 1,0,0,8'h00,0,0,0);
    add(0,1,8'hB2,0,0,3,0, 1,1,2,8'hB2,0,0,0);
    add(0,0,8'h00,0,0,3,0, 1,0,0,8'h00,0,0,0);
    add(0,1,8'hB3,0,0,3,0, 0,1,3,8'hB3,0,0,1);
    add(0,0,8'h00,0,0,3,0, 0,0,0,8'h00,1,0,1);
    // Ping-pong: 2 words/layer, depth 2; stray done2, stall, done2 mid-write
    add(1,0,8'h00,0,0,1,2, 0,0,0,8'h00,0,0,0);
    add(0,1,8'hC0,0,1,1,2, 1,0,0,8'h00,0,0,0);
    add(0,1,8'hC0,0,0,1,2, 1,1,0,8'hC0,0,0,0);
    add(0,1,8'hC1,0,0,1,2, 0,1,1,8'hC1,0,0,0);
    add(0,1,8'hC2,0,0,1,2, 1,0,0,8'h00,1,0,0);
    add(0,1,8'hC2,0,0,1,2, 1,1,64,8'hC2,1,0,0);
    add(0,1,8'hC3,0,0,1,2, 0,1,65,8'hC3,1,0,0);
    add(0,1,8'hC4,0,0,1,2, 0,0,0,8'h00,1,1,0);
    add(0,1,8'hC4,0,0,1,2, 0,0,0,8'h00,1,1,0);
    add(0,1,8'hC4,1,0,1,2, 0,0,0,8'h00,0,1,0);
    add(0,1,8'hC4,0,0,1,2, 1,0,0,8'h00,0,1,0);
    add(0,1,8'hC4,0,1,1,2, 1,1,0,8'hC4,0,0,0);
    add(0,1,8'hC5,0,0,1,2, 0,1,1,8'hC5,0,0,1);
    add(0,0,8'h00,0,0,1,2, 0,0,0,8'h00,1,0,1);

    rst_n_i = 1'b0; start_i = 1'b0; layer_words_i = '0; exp3_ker_depth_i = '0;
    ker_data_i = '0; ker_data_valid_i = 1'b0; layer_1_done_i = 1'b0; layer_2_done_i = 1'b0;
    repeat (3) step();
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk_wr("reset", 7'd0, 8'h00);
`ifdef EXP3_KER_WR_ERR_CHK_EN
    chk("reset_err", {63'd0, err_o}, 64'd0);
`endif
    rst_n_i = 1'b1;
    step();
    chk_outs("idle", 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      start_i          = tbl[i].start;
      ker_data_valid_i = tbl[i].valid;
      ker_data_i       = {56'd0, tbl[i].data};
      layer_1_done_i   = tbl[i].d1;
      layer_2_done_i   = tbl[i].d2;
      layer_words_i    = tbl[i].lw;
      exp3_ker_depth_i = tbl[i].dep;
      step();
      chk_outs(tag, tbl[i].rdy, tbl[i].en, tbl[i].l1, tbl[i].l2, tbl[i].fend);
      if (tbl[i].en) chk_wr(tag, tbl[i].addr, tbl[i].edata);
    end
    start_i = 1'b0; ker_data_valid_i = 1'b0; layer_1_done_i = 1'b0; layer_2_done_i = 1'b0;

    // Restart mid-fill: start after 2 of 4 words, writes restart at address 0
    layer_words_i = 7'd3; exp3_ker_depth_i = 6'd0;
    start_i = 1'b1; step(); start_i = 1'b0;
    ker_data_valid_i = 1'b1; ker_data_i = 64'hD0; step();
    step();
    chk_outs("rs_w0", 1, 1, 0, 0, 0);
    chk_wr("rs_w0", 7'd0, 8'hD0);
    ker_data_i = 64'hD1; step();
    chk_wr("rs_w1", 7'd1, 8'hD1);
    start_i = 1'b1; ker_data_i = 64'hD2; step(); start_i = 1'b0;
    chk_outs("rs_restart", 0, 0, 0, 0, 0);
    step();
    chk_outs("rs_wait", 1, 0, 0, 0, 0);
    step();
    chk_outs("rs_again0", 1, 1, 0, 0, 0);
    chk_wr("rs_again0", 7'd0, 8'hD2);
    ker_data_i = 64'hD3; step();
    chk_wr("rs_again1", 7'd1, 8'hD3);

    // Asynchronous reset in the middle of WRITE, away from the clock edge
    rst_n_i = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 0, 0, 0);
    chk_wr("async_rst", 7'd0, 8'h00);
    ker_data_valid_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    chk_outs("after_rst", 0, 0, 0, 0, 0);

`ifdef EXP3_KER_WR_ERR_CHK_EN
    chk("err_idle", {63'd0, err_o}, 64'd0);
    start_i = 1'b1; step(); start_i = 1'b0;
    layer_1_done_i = 1'b1; step(); layer_1_done_i = 1'b0;
    chk("err_set", {63'd0, err_o}, 64'd1);
    repeat (3) step();
    chk("err_hold", {63'd0, err_o}, 64'd1);
    start_i = 1'b1; step(); start_i = 1'b0;
    chk("err_clr", {63'd0, err_o}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exp_3x3_ker_write_cont.md
Name: exp_3x3_ker_write_cont

Overview:
Fills the expand 3x3 kernel RAM from the weight-loader stream, alternating between the two ping-pong layers: layer 1 at addresses 0..63 and layer 2 at 64..127.
It raises layer_1_ready_o / layer_2_ready_o when a layer is fully written, and frees the layer on the matching layer_x_done_i pulse from the kernel read controller.
It sits between the weight-loader DMA stream and the kernel RAM write port.

Parameters:
DATA_W, 64, kernel RAM word width (bits of ker_data_i / exp_3x3_ram_wr_data_o)
LAYER2_BASE, 64, base write address of layer 2 (layer 1 base is 0)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  synchronous restart pulse; samples configuration
layer_words_i  in  7  words per layer minus 1 (0..63)
exp3_ker_depth_i  in  6  number of layer fills minus 1
ker_data_i  in  DATA_W  kernel word from loader
ker_data_valid_i  in  1  loader word valid
ker_data_ready_o  out  1  block accepts word this cycle
exp_3x3_ram_wr_addr_o  out  7  RAM write address
exp_3x3_ram_wr_data_o  out  DATA_W  RAM write data
exp_3x3_ram_wr_en_o  out  1  RAM write enable
layer_1_ready_o  out  1  layer 1 holds a complete kernel set
layer_1_done_i  in  1  pulse: reader finished layer 1
layer_2_ready_o  out  1  layer 2 holds a complete kernel set
layer_2_done_i  in  1  pulse: reader finished layer 2
fill_end_o  out  1  all depth+1 fills written (level, cleared by start_i)

Behaviour:
- Reset (rst_n_i low, asynchronous): all outputs 0, FSM in IDLE, counters 0, config registers 0.
- start_i (synchronous, highest priority after reset):
  - clears all outputs, ready flags and counters, in any state;
  - latches layer_words_i and exp3_ker_depth_i;
  - selects layer 1 and enters WAIT_FREE next cycle.
- FSM states: IDLE, WAIT_FREE, WRITE, END.
  - IDLE: waits for start_i.
  - WAIT_FREE: moves to WRITE when the selected layer's ready flag is 0.
  - WRITE: ker_data_ready_o = 1 (combinational from state only, no dependence on valid). A word is accepted when valid && ready. The accept of word number layer_words moves to WAIT_FREE with the layer toggled, or to END if the fill count equals depth.
  - END: fill_end_o = 1; ker_data_ready_o = 0. Stays until start_i.
- Write latency: accept at cycle N gives exp_3x3_ram_wr_en_o = 1 at N+1, with addr = base + word count and data = registered ker_data_i. Back-to-back accepts give contiguous addresses.
- Word count is 6 bits. It resets to 0 at each layer start and never carries into bit 6; address = {layer_sel, count} when LAYER2_BASE = 64.
- Ready flags:
  - The selected layer's ready flag is set at N+2 after its final accept, so the RAM write has landed.
  - layer_x_done_i clears layer x ready the next cycle.
  - done_i for a layer whose ready flag is 0 is ignored.
  - done_i for the layer not currently being written is honoured during WRITE.
- Simultaneous events:
  - layer_1_done_i and layer_2_done_i together: both cleared.
  - Set and clear of the same flag in the same cycle cannot occur, because a layer is written only when its flag is 0.
- Depth 0: one fill (layer 1 only), then END.
- ker_data_valid_i while not in WRITE: word is not accepted; loader must hold it.

Optional Feature:
EXP3_KER_WR_ERR_CHK_EN
- Defined: adds output err_o (1 bit, reset 0), a sticky flag set when:
  - layer_x_done_i arrives while layer x ready is 0, or
  - ker_data_valid_i is high in END.
  err_o is cleared by start_i or reset.
- Undefined: port and logic absent; such events are silently ignored.

Decomposition:
- Shared package exp_3x3_pkg holds:
  - FSM state enum (IDLE, WAIT_FREE, WRITE, END);
  - LAYER1_BASE = 0, LAYER2_BASE = 64;
  - RAM address width 7.
- Sub-module exp_3x3_layer_flag, instantiated twice, implements one ready flag:
  - inputs: set, done, start;
  - outputs: ready, and err_pulse when EXP3_KER_WR_ERR_CHK_EN is defined.

Test Plan:
- Basic fill:
  - stimulus: start_i with layer_words=3, depth=0; valid held high; words 0xA0..0xA3.
  - response: wr_en at addrs 0,1,2,3 on consecutive cycles; layer_1_ready_o rises 2 cycles after final accept; fill_end_o = 1; layer 2 untouched.
- Ping-pong:
  - stimulus: layer_words=1, depth=2.
  - response: layer 1 written at 0,1 then layer 2 at 64,65. Block stalls in WAIT_FREE (ready_o = 0) until layer_1_done_i, then rewrites 0,1; fill_end_o then 1.
- Backpressure/bubbles:
  - stimulus: valid toggled 1,0,1,0.
  - response: addresses increment only on accepts; no wr_en on bubble cycles.
- Done during write:
  - stimulus: layer_2_done_i pulsed while layer 1 is being written.
  - response: layer_2_ready_o clears next cycle; writes continue unaffected.
- Restart mid-fill:
  - stimulus: start_i after 2 of 4 words.
  - response: next cycle both ready flags 0; subsequent writes restart at addr 0.
  - stimulus: async rst_n_i low mid-WRITE.
  - response: all outputs 0 immediately.
- Error check (macro defined):
  - stimulus: layer_1_done_i with layer_1_ready_o = 0.
  - response: err_o = 1 and held until start_i.
